// File: rtl/alu_exec_unit_if.sv
// Issue/result handshake bundle for the execution-stage ALU.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_con_in;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal_op;

  // Issuer / result consumer side.
  modport master (
    output in_valid, alu_con_in, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );

  // ALU side.
  modport slave (
    input  in_valid, alu_con_in, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: one-cycle logic/arithmetic, bit-serial shifts, registered result
// with valid/ready handshakes on both issue and result sides.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_exec_unit_if.slave    bus
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpXor = 4'b1000;
  localparam logic [3:0] OpSll = 4'b1001;
  localparam logic [3:0] OpSrl = 4'b1010;
  localparam logic [3:0] OpSra = 4'b1011;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {KindSll, KindSrl, KindSra} kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sh_next;

  assign shamt = bus.op_b[SHW-1:0];

  // Single-cycle datapath; shifts only reach this result when shamt is zero.
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (bus.alu_con_in)
      OpAnd: alu_res = bus.op_a & bus.op_b;
      OpOr:  alu_res = bus.op_a | bus.op_b;
      OpAdd: alu_res = bus.op_a + bus.op_b;
      OpSub: alu_res = bus.op_a - bus.op_b;
      OpSlt: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OpXor: alu_res = bus.op_a ^ bus.op_b;
      OpSll, OpSrl, OpSra: begin
        is_shift = 1'b1;
        alu_res  = bus.op_a;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit-per-cycle shift step for the iterative path.
  always_comb begin
    sh_next = sh_q;
    unique case (kind_q)
      KindSll: sh_next = {sh_q[XLEN-2:0], 1'b0};
      KindSrl: sh_next = {1'b0, sh_q[XLEN-1:1]};
      KindSra: sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
      default: sh_next = sh_q;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (is_shift && (shamt != '0)) begin
            sh_d  = bus.op_a;
            cnt_d = shamt;
            unique case (bus.alu_con_in)
              OpSll:   kind_d = KindSll;
              OpSrl:   kind_d = KindSrl;
              default: kind_d = KindSra;
            endcase
            state_d = StShift;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = StDone;
          end
        end
      end
      StShift: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          result_d  = sh_next;
          zero_d    = (sh_next == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      kind_q    <= KindSll;
      sh_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // Handshake flags decode from state only.
  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.result     = result_q;
  assign bus.zero       = zero_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, random ops vs. reference model,
// and hand sequences for reset, backpressure and mid-shift reset.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation table.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: r = a ^ b;
      4'b1001: r = a << b[4:0];
      4'b1010: r = a >> b[4:0];
      4'b1011: r = $signed(a) >>> b[4:0];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_ill(input logic [3:0] op);
    return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
                        4'b1001, 4'b1010, 4'b1011});
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    return (op inside {4'b1001, 4'b1010, 4'b1011}) ? int'(b[4:0]) : 0;
  endfunction

  // Called just after a clock edge; returns once out_valid is seen (or budget runs out).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    bus.in_valid   = 1'b1;
    bus.alu_con_in = op;
    bus.op_a       = a;
    bus.op_b       = b;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: they must not matter any more.
    bus.in_valid   = 1'b0;
    bus.alu_con_in = 4'($urandom);
    bus.op_a       = $urandom;
    bus.op_b       = $urandom;
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic handshake(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({name, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic z,
                        input logic ill, input int lat);
    int cyc;
    issue(op, a, b, cyc);
    chk({name, "_lat"}, 32'(cyc), 32'(lat));
    chk({name, "_res"}, bus.result, res);
    chk({name, "_zero"}, 32'(bus.zero), 32'(z));
    chk({name, "_ill"}, 32'(bus.illegal_op), 32'(ill));
  endtask

  initial begin
    int   cyc;
    logic seen;
    logic [3:0]  op;
    logic [31:0] a, b, r;

    vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 0};
    vecs[1]  = '{4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 0};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 0};
    vecs[3]  = '{4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 0};
    vecs[4]  = '{4'b1011, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 1'b0, 31};
    vecs[5]  = '{4'b1010, 32'h8000_0000, 32'h1F, 32'h1, 1'b0, 1'b0, 31};
    vecs[6]  = '{4'b1001, 32'h1, 32'h0, 32'h1, 1'b0, 1'b0, 0};
    vecs[7]  = '{4'b1001, 32'h1, 32'h24, 32'h10, 1'b0, 1'b0, 4};
    vecs[8]  = '{4'b0101, 32'd123, 32'd456, 32'h0, 1'b1, 1'b1, 0};
    vecs[9]  = '{4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, 0};
    vecs[10] = '{4'b0001, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 0};

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.alu_con_in = '0;
    bus.op_a       = '0;
    bus.op_b       = '0;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_zero", 32'(bus.zero), 32'd0);

    // Asynchronous reset while holding a result in DONE.
    issue(4'b0001, 32'h1, 32'h2, cyc);
    chk("pre_rst_res", bus.result, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_res", bus.result, 32'd0);
    chk("async_rst_ready", 32'(bus.in_ready), 32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].z, vecs[i].ill, vecs[i].lat);
      handshake($sformatf("vec%0d", i));
    end

    // Illegal then legal AND: illegal_op must clear.
    run_op("ill", 4'b1111, 32'hDEAD, 32'hBEEF, 32'h0, 1'b1, 1'b1, 0);
    handshake("ill");
    run_op("and_after_ill", 4'b0000, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0, 0);
    handshake("and_after_ill");

    // Backpressure: DONE holds, new issues ignored.
    issue(4'b1000, 32'hF0F0, 32'hFF00, cyc);
    bus.in_valid   = 1'b1;
    bus.alu_con_in = 4'b0010;
    bus.op_a       = 32'h1234;
    bus.op_b       = 32'h1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_res%0d", i), bus.result, 32'h0FF0);
      chk($sformatf("bp_ready%0d", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    handshake("bp");

    // Reset in the middle of a long shift: op is dropped.
    issue(4'b1001, 32'h1, 32'd20, cyc);
    bus.alu_con_in = 4'b0000;
    // issue() already waited out the shift; redo with manual timing.
    handshake("pre_midrst");
    bus.in_valid   = 1'b1;
    bus.alu_con_in = 4'b1001;
    bus.op_a       = 32'h1;
    bus.op_b       = 32'd20;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    run_op("after_midrst", 4'b0010, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 0);
    handshake("after_midrst");

    // Random ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000 | a;
      if ($urandom_range(0, 7) == 0) b = a;
      r = ref_res(op, a, b);
      run_op($sformatf("rnd%0d_op%0h", i, op), op, a, b, r, (r == 32'd0), ref_ill(op),
             ref_lat(op, b));
      handshake($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two XLEN-bit operands, and returns a registered result. Logical and arithmetic ops complete in one cycle. Shifts are computed iteratively, one bit position per cycle, to save area. Valid/ready handshakes are provided on both the issue side and the result side so the block can stall the pipeline.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- SHW, log2(XLEN): shift-amount width (5 for XLEN=32).

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  issue request valid.
- in_ready  out  1  block can accept an issue.
- alu_con_in  in  4  ALU operation code from the control decoder.
- op_a  in  XLEN  operand A (rs1).
- op_b  in  XLEN  operand B (rs2 or immediate); op_b[SHW-1:0] is the shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0 (branch compare).
- illegal_op  out  1  alu_con_in was not a defined code.

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 XOR, 1001 SLL, 1010 SRL, 1011 SRA.
- Any other code: result = 0, zero = 1, illegal_op = 1. Completes as a one-cycle op.
- ADD/SUB wrap modulo 2^XLEN; no carry or overflow output.
- SLT: result = {XLEN-1 zeros, ($signed(op_a) < $signed(op_b))}.
- Shifts: shamt = op_b[SHW-1:0]; upper op_b bits are ignored. SRA replicates op_a[XLEN-1]; SLL/SRL fill with 0.
- zero and illegal_op are registered alongside result and describe the same transaction.
- FSM states:
  - IDLE: in_ready = 1. On in_valid:
    - shift op with shamt > 0: latch op_a into the shift register, cnt = shamt, op kind; go to SHIFT.
    - otherwise: compute and register result/zero/illegal_op; go to DONE.
  - SHIFT: in_ready = 0. Each cycle shift the register by one bit and decrement cnt. On the edge where cnt == 1, register the final result and zero, then go to DONE.
  - DONE: out_valid = 1 and in_ready = 0. result, zero and illegal_op are held stable. On out_ready go to IDLE.
- in_ready is decoded from state only. There is no combinational path from in_valid or out_ready to in_ready.
- Inputs are sampled only on the accept edge. Changes to op_a, op_b or alu_con_in afterward have no effect.

## Timing
- Reset (asynchronous assert, any state, including mid-shift): state = IDLE, out_valid = 0, result = 0, zero = 0, illegal_op = 0, cnt = 0. After reset, in_ready = 1. An in-flight shift is discarded and produces no output.
- Accept edge E0 = the rising edge where in_valid && in_ready.
- Non-shift ops, illegal ops, and shifts with shamt = 0: out_valid is high from E0 (visible the following cycle).
- Shift with shamt = n > 0: out_valid is high from E0 + n. Maximum is XLEN−1 extra cycles.
- Result handshake completes on an edge with out_valid && out_ready. The state is IDLE after that edge.
- Peak throughput is one op per 2 cycles. A new accept is not possible on the same edge as a result handshake.
- out_ready held low: DONE persists indefinitely with result unchanged. in_valid is ignored.
- in_valid asserted while not IDLE: ignored. The issuer must hold it until in_ready.

## Test plan
- Reset then idle: assert rst_n = 0 mid-cycle → outputs go to 0 immediately, in_ready = 1. Release, then issue ADD 0xFFFFFFFF + 1 → result = 0x00000000, zero = 1, out_valid one edge after accept.
- SUB/SLT: SUB 5 − 7 → 0xFFFFFFFE, zero = 0. SLT 0xFFFFFFFF vs 1 → 1. SLT 1 vs 0xFFFFFFFF → 0.
- Shifts with latency check: SRA 0x80000000 by op_b = 0x0000001F → 0xFFFFFFFF with out_valid at E0 + 31. SRL same operands → 0x00000001. SLL 0x1 by 0 → 0x1 at E0. op_b = 0x24 → shamt 4.
- Backpressure: hold out_ready = 0 for 10 cycles after an XOR 0xF0F0 ^ 0xFF00 → result 0x0FF0 stable throughout, in_ready = 0, intervening in_valid ignored. Release out_ready → IDLE next edge.
- Illegal code 0101 → result 0, zero = 1, illegal_op = 1 at E0. The next legal AND clears illegal_op.
- Reset during SHIFT (SLL shamt 20, reset at E0 + 5) → no out_valid ever asserted for that op. The next op completes normally.
